// File: rtl/lifo_arbiter.sv
// Two-client round-robin sequencer in front of a 32-bit x 1024 LIFO.
// Ports: clk, rst (sync, active-high).
//   Client side: req/op/wdata in; gnt/err/rvalid/rdata/err_cnt out.
//   LIFO side: lifo_wr/lifo_rd/lifo_din out; lifo_dout/full/empty in.
module lifo_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        op0,
  input  logic        op1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        err0,
  output logic        err1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [7:0]  err_cnt0,
  output logic [7:0]  err_cnt1,
  output logic        lifo_wr,
  output logic        lifo_rd,
  output logic [31:0] lifo_din,
  input  logic [31:0] lifo_dout,
  input  logic        lifo_full,
  input  logic        lifo_empty
);

  typedef enum logic [1:0] {
    IDLE,
    PUSH,
    POP,
    CAPT
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             win_q, win_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       err_q, err_d;
  logic [1:0]       rvalid_q, rvalid_d;
  logic [1:0][31:0] rdata_q, rdata_d;
  logic [1:0][7:0]  cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic [31:0]      din_q, din_d;

  logic [1:0]       req;
  logic [1:0]       op;
  logic [1:0][31:0] wdata;
  logic             sel;
  logic             refuse;

  assign req   = {req1, req0};
  assign op    = {op1, op0};
  assign wdata = {wdata1, wdata0};

  // On a tie the client not served last wins.
  assign sel    = (&req) ? ~last_q : req[1];
  assign refuse = op[sel] ? lifo_empty : lifo_full;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    win_d    = win_q;
    gnt_d    = '0;
    err_d    = '0;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    din_d    = din_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          win_d      = sel;
          last_d     = sel;
          gnt_d[sel] = 1'b1;
          if (refuse) begin
            // Refusal occupies the one-cycle slot with no strobe.
            err_d[sel] = 1'b1;
            if (cnt_q[sel] != 8'hff) begin
              cnt_d[sel] = cnt_q[sel] + 8'd1;
            end
            state_d = PUSH;
          end else if (op[sel]) begin
            rd_d    = 1'b1;
            state_d = POP;
          end else begin
            wr_d    = 1'b1;
            din_d   = wdata[sel];
            state_d = PUSH;
          end
        end
      end
      PUSH: state_d = IDLE;
      POP:  state_d = CAPT;
      CAPT: begin
        rdata_d[win_q]  = lifo_dout;
        rvalid_d[win_q] = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      gnt_q    <= '0;
      err_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      win_q    <= win_d;
      gnt_q    <= gnt_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      din_q    <= din_d;
    end
  end

  assign gnt0     = gnt_q[0];
  assign gnt1     = gnt_q[1];
  assign err0     = err_q[0];
  assign err1     = err_q[1];
  assign rvalid0  = rvalid_q[0];
  assign rvalid1  = rvalid_q[1];
  assign rdata0   = rdata_q[0];
  assign rdata1   = rdata_q[1];
  assign err_cnt0 = cnt_q[0];
  assign err_cnt1 = cnt_q[1];
  assign lifo_wr  = wr_q;
  assign lifo_rd  = rd_q;
  assign lifo_din = din_q;

endmodule

// File: tb/tb_lifo_arbiter.sv
// Bench for lifo_arbiter: LIFO stub, transaction-level reference model,
// per-cycle output compare and directed scenarios with literal checks.
module tb_lifo_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req0, req1, op0, op1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, err0, err1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic [7:0]  err_cnt0, err_cnt1;
  logic        lifo_wr, lifo_rd;
  logic [31:0] lifo_din, lifo_dout;
  logic        lifo_full, lifo_empty;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  lifo_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .err0(err0), .err1(err1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .err_cnt0(err_cnt0), .err_cnt1(err_cnt1),
    .lifo_wr(lifo_wr), .lifo_rd(lifo_rd), .lifo_din(lifo_din),
    .lifo_dout(lifo_dout), .lifo_full(lifo_full), .lifo_empty(lifo_empty)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // LIFO stub driven by the DUT strobes.
  logic [31:0] s_mem [1024];
  int s_sp = 0;
  always @(posedge clk) begin
    if (rst) s_sp <= 0;
    else if (lifo_wr) begin
      s_mem[s_sp] <= lifo_din;
      s_sp <= s_sp + 1;
    end else if (lifo_rd) begin
      lifo_dout <= s_mem[s_sp-1];
      s_sp <= s_sp - 1;
    end
  end
  assign lifo_full  = (s_sp == 1024);
  assign lifo_empty = (s_sp == 0);

  // Reference model: a request is taken when the arbiter is free, the
  // grant shows next cycle, a push/refusal keeps it busy 2 cycles and a
  // pop 3 cycles with data returned 3 cycles after the request.
  logic [31:0] m_stack [1024];
  int          m_sp = 0, m_wait = 0, m_pend = 0, m_pw = 0;
  int          m_cnt [2];
  logic [31:0] m_rdata [2];
  logic        m_last;
  logic [31:0] m_pval, m_din;
  logic [1:0]  e_gnt = '0, e_err = '0, e_rv = '0;
  logic        e_wr = 1'b0, e_rd = 1'b0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin : model
    logic [1:0] rq, o;
    int w;
    bit rf;
    e_gnt = '0; e_err = '0; e_rv = '0; e_wr = 1'b0; e_rd = 1'b0;
    rq = {req1, req0};
    o  = {op1, op0};
    if (rst) begin
      m_sp = 0; m_wait = 0; m_pend = 0; m_last = 1'b1; m_din = '0;
      m_rdata[0] = '0; m_rdata[1] = '0; m_cnt[0] = 0; m_cnt[1] = 0;
      chk_en = 1'b1;
    end else begin
      if (m_pend > 0) begin
        m_pend--;
        if (m_pend == 0) begin
          e_rv[m_pw] = 1'b1;
          m_rdata[m_pw] = m_pval;
        end
      end
      if (m_wait > 0) m_wait--;
      else if (rq != 2'b00) begin
        if (rq == 2'b11) w = m_last ? 0 : 1;
        else w = rq[1] ? 1 : 0;
        m_last = (w == 1);
        e_gnt[w] = 1'b1;
        rf = o[w] ? (m_sp == 0) : (m_sp == 1024);
        if (rf) begin
          e_err[w] = 1'b1;
          if (m_cnt[w] < 255) m_cnt[w]++;
          m_wait = 1;
        end else if (o[w]) begin
          e_rd = 1'b1;
          m_sp--;
          m_pval = m_stack[m_sp];
          m_pw = w; m_pend = 2; m_wait = 2;
        end else begin
          e_wr = 1'b1;
          m_din = (w == 0) ? wdata0 : wdata1;
          m_stack[m_sp] = m_din;
          m_sp++;
          m_wait = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("gnt", 32'({gnt1, gnt0}), 32'(e_gnt));
      chk("err", 32'({err1, err0}), 32'(e_err));
      chk("rvalid", 32'({rvalid1, rvalid0}), 32'(e_rv));
      chk("strobes", 32'({lifo_wr, lifo_rd}), 32'({e_wr, e_rd}));
      chk("rdata0", rdata0, m_rdata[0]);
      chk("rdata1", rdata1, m_rdata[1]);
      chk("lifo_din", lifo_din, m_din);
      chk("err_cnt0", 32'(err_cnt0), 32'(m_cnt[0]));
      chk("err_cnt1", 32'(err_cnt1), 32'(m_cnt[1]));
    end
  end

  int          glog[$];
  logic [31:0] r0log[$];
  int          rv0_cnt = 0, rv1_cnt = 0, rv0_cyc = 0;
  always @(negedge clk) begin
    if (gnt0) glog.push_back(0);
    if (gnt1) glog.push_back(1);
    if (rvalid0) begin
      rv0_cnt++;
      rv0_cyc = cyc;
      r0log.push_back(rdata0);
    end
    if (rvalid1) rv1_cnt++;
  end

  task automatic client_req(input int c, input logic o, input logic [31:0] d,
                            output logic e, output logic wr, output logic rd,
                            output int lat);
    int t0;
    bit got;
    t0 = cyc; got = 0; e = 1'b0; wr = 1'b0; rd = 1'b0; lat = -1;
    if (c == 0) begin req0 = 1'b1; op0 = o; wdata0 = d; end
    else begin req1 = 1'b1; op1 = o; wdata1 = d; end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((c == 0) ? gnt0 : gnt1) begin
        got = 1;
        e   = (c == 0) ? err0 : err1;
        wr  = lifo_wr;
        rd  = lifo_rd;
        lat = cyc - t0;
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL gnt_timeout client=%0d got=none want=gnt", c);
    end
    if (c == 0) req0 = 1'b0;
    else req1 = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic e, wr, rd;
    int lat, t0, n0;
    int exp_g [4];
    logic [31:0] exp_r [4];
    bit ok;
    exp_g = '{0, 1, 0, 1};
    exp_r = '{32'hB, 32'h2, 32'hA, 32'h1};
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
    wdata0 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_outs", 32'({gnt0, gnt1, err0, err1, rvalid0, rvalid1,
                         lifo_wr, lifo_rd}), 32'h0);
    chk("rst_rdata0", rdata0, 32'h0);
    rst = 1'b0;

    // single push, then pop
    client_req(0, 1'b0, 32'hDEADBEEF, e, wr, rd, lat);
    chk("push_lat", 32'(lat), 32'd1);
    chk("push_wr", 32'(wr), 32'd1);
    chk("push_err", 32'(e), 32'd0);
    @(negedge clk);
    r0log.delete();
    t0 = cyc;
    client_req(0, 1'b1, 32'h0, e, wr, rd, lat);
    chk("pop_lat", 32'(lat), 32'd1);
    chk("pop_rd", 32'(rd), 32'd1);
    repeat (4) @(negedge clk);
    chk("pop_rv_lat", 32'(rv0_cyc - t0), 32'd3);
    chk("pop_rv_n", 32'(r0log.size()), 32'd1);
    chk("pop_rdata0", rdata0, 32'hDEADBEEF);
    chk("pop_rdata1", rdata1, 32'h0);

    // tie arbitration
    reset_dut();
    glog.delete();
    fork
      begin : c0
        logic e0, w0, r0; int l0;
        client_req(0, 1'b0, 32'h1, e0, w0, r0, l0);
        client_req(0, 1'b0, 32'h2, e0, w0, r0, l0);
      end
      begin : c1
        logic e1, w1, r1; int l1;
        client_req(1, 1'b0, 32'hA, e1, w1, r1, l1);
        client_req(1, 1'b0, 32'hB, e1, w1, r1, l1);
      end
    join
    repeat (2) @(negedge clk);
    chk("tie_n", 32'(glog.size()), 32'd4);
    for (int i = 0; i < 4 && i < glog.size(); i++)
      chk("tie_order", 32'(glog[i]), 32'(exp_g[i]));
    r0log.delete();
    for (int i = 0; i < 4; i++) client_req(0, 1'b1, 32'h0, e, wr, rd, lat);
    repeat (4) @(negedge clk);
    chk("lifo_n", 32'(r0log.size()), 32'd4);
    for (int i = 0; i < 4 && i < r0log.size(); i++)
      chk("lifo_order", r0log[i], exp_r[i]);

    // pop on empty
    reset_dut();
    n0 = rv1_cnt;
    client_req(1, 1'b1, 32'h0, e, wr, rd, lat);
    chk("empty_err", 32'(e), 32'd1);
    chk("empty_strb", 32'({wr, rd}), 32'd0);
    chk("empty_lat", 32'(lat), 32'd1);
    repeat (4) @(negedge clk);
    chk("empty_cnt1", 32'(err_cnt1), 32'd1);
    chk("empty_rv1", 32'(rv1_cnt), 32'(n0));

    // push on full
    reset_dut();
    for (int i = 0; i < 1024; i++) client_req(0, 1'b0, 32'(i), e, wr, rd, lat);
    @(negedge clk);
    chk("full_flag", 32'(lifo_full), 32'd1);
    client_req(0, 1'b0, 32'h55, e, wr, rd, lat);
    chk("full_err", 32'(e), 32'd1);
    chk("full_strb", 32'({wr, rd}), 32'd0);
    @(negedge clk);
    chk("full_din", lifo_din, 32'd1023);

    // counter saturation
    reset_dut();
    ok = 1;
    for (int i = 0; i < 260; i++) begin
      client_req(0, 1'b1, 32'h0, e, wr, rd, lat);
      if (e !== 1'b1) ok = 0;
    end
    chk("sat_all_err", 32'(ok), 32'd1);
    @(negedge clk);
    chk("sat_cnt", 32'(err_cnt0), 32'd255);
    client_req(0, 1'b1, 32'h0, e, wr, rd, lat);
    chk("sat_err", 32'(e), 32'd1);
    @(negedge clk);
    chk("sat_hold", 32'(err_cnt0), 32'd255);

    // reset mid-pop
    reset_dut();
    client_req(0, 1'b0, 32'h77, e, wr, rd, lat);
    client_req(0, 1'b0, 32'h88, e, wr, rd, lat);
    client_req(0, 1'b1, 32'h0, e, wr, rd, lat);
    repeat (3) @(negedge clk);
    chk("mid_first", rdata0, 32'h88);
    n0 = rv0_cnt;
    req0 = 1'b1; op0 = 1'b1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (gnt0) ok = 1;
    end
    chk("mid_gnt", 32'(ok), 32'd1);
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_outs", 32'({gnt0, gnt1, err0, err1, rvalid0, rvalid1,
                         lifo_wr, lifo_rd}), 32'h0);
    chk("mid_rdata0", rdata0, 32'h0);
    chk("mid_din", lifo_din, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_no_rv", 32'(rv0_cnt), 32'(n0));
    glog.delete();
    fork
      begin : d0
        logic e0, w0, r0; int l0;
        client_req(0, 1'b0, 32'h10, e0, w0, r0, l0);
      end
      begin : d1
        logic e1, w1, r1; int l1;
        client_req(1, 1'b0, 32'h20, e1, w1, r1, l1);
      end
    join
    repeat (2) @(negedge clk);
    chk("mid_tie_n", 32'(glog.size()), 32'd2);
    if (glog.size() > 0) chk("mid_tie_first", 32'(glog[0]), 32'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
